// File: rtl/jzjpcc_pkg.sv
// Shared types and constants for the jzjpcc front end.
package jzjpcc_pkg;

  typedef logic [31:0] word_t;

  // RISC-V "addi x0, x0, 0": presented to decode whenever no entry is valid.
  localparam word_t NOP = 32'h00000013;

endpackage

// File: rtl/jzjpcc_instruction_queue.sv
// Instruction queue between fetch and decode: register-array FIFO with
// one-cycle latency, registered-only decode outputs and a flush for redirects.
module jzjpcc_instruction_queue
  import jzjpcc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       fetchValid,
  output logic                       fetchReady,
  input  logic [31:0]                fetchPC,
  input  logic [31:0]                fetchInstruction,
  output logic                       decodeValid,
  input  logic                       decodeReady,
  output logic [31:0]                decodePC,
  output logic [31:0]                decodeInstruction,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  word_t pc_mem    [DEPTH];
  word_t instr_mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          enq;
  logic          deq;

  // Ready/valid are functions of the stored count only, so neither side
  // sees a combinational path from the other.
  assign fetchReady  = (count != FULL_COUNT);
  assign decodeValid = (count != '0);

  assign enq = fetchValid  && fetchReady  && !flush;
  assign deq = decodeValid && decodeReady && !flush;

  assign decodePC          = decodeValid ? pc_mem[rd_ptr]    : 32'h00000000;
  assign decodeInstruction = decodeValid ? instr_mem[rd_ptr] : NOP;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; the count gates every read.
  always_ff @(posedge clock) begin
    if (!reset && enq) begin
      pc_mem[wr_ptr]    <= fetchPC;
      instr_mem[wr_ptr] <= fetchInstruction;
    end
  end

endmodule

// File: tb/tb_jzjpcc_instruction_queue.sv
// Scoreboard bench for jzjpcc_instruction_queue (DEPTH=4).
module tb_jzjpcc_instruction_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetchValid;
  logic        fetchReady;
  logic [31:0] fetchPC;
  logic [31:0] fetchInstruction;
  logic        decodeValid;
  logic        decodeReady;
  logic [31:0] decodePC;
  logic [31:0] decodeInstruction;
  logic        flush;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  jzjpcc_instruction_queue #(.DEPTH(DEPTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .fetchValid        (fetchValid),
    .fetchReady        (fetchReady),
    .fetchPC           (fetchPC),
    .fetchInstruction  (fetchInstruction),
    .decodeValid       (decodeValid),
    .decodeReady       (decodeReady),
    .decodePC          (decodePC),
    .decodeInstruction (decodeInstruction),
    .flush             (flush),
    .count             (count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return (pc * 32'd3) ^ 32'h5A5A0003;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc);
    fetchValid       = 1'b1;
    fetchPC          = pc;
    fetchInstruction = ins_of(pc);
  endtask

  // Mid-cycle: compare DUT against the model state, then advance the model
  // using the inputs that will be sampled at the coming edge.
  always @(negedge clock) begin
    if (!reset) begin
      check("count",       32'(count),       32'(sb.size()));
      check("decodeValid", 32'(decodeValid), 32'(sb.size() != 0));
      check("fetchReady",  32'(fetchReady),  32'(sb.size() != DEPTH));
      if (sb.size() != 0) begin
        check("decodePC",  decodePC,          sb[0].pc);
        check("decodeIns", decodeInstruction, sb[0].ins);
      end else begin
        check("idlePC",    decodePC,          32'h0);
        check("idleIns",   decodeInstruction, 32'h00000013);
      end
    end
    if (reset || flush) begin
      sb.delete();
    end else begin
      logic do_enq;
      logic do_deq;
      do_enq = fetchValid && (sb.size() != DEPTH);
      do_deq = decodeReady && (sb.size() != 0);
      if (do_deq) void'(sb.pop_front());
      if (do_enq) sb.push_back('{pc: fetchPC, ins: fetchInstruction});
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; fetchValid = 1'b0; decodeReady = 1'b0;
    fetchPC = '0; fetchInstruction = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_valid", 32'(decodeValid), 32'd0);
    check("rst_ready", 32'(fetchReady),  32'd1);
    check("rst_count", 32'(count),       32'd0);
    check("rst_ins",   decodeInstruction, 32'h00000013);

    // Three entries held, then drained in order.
    for (int i = 0; i < 3; i++) begin offer(32'(4 * i)); tick(); end
    fetchValid = 1'b0;
    tick();
    check("hold3_count", 32'(count), 32'd3);
    check("hold3_pc",    decodePC,   32'h0);
    decodeReady = 1'b1;
    tick(); tick(); tick();
    decodeReady = 1'b0;
    check("drain_count", 32'(count), 32'd0);

    // Fill to full; fifth offer is refused; one dequeue reopens.
    for (int i = 0; i < 4; i++) begin offer(32'h100 + 32'(4 * i)); tick(); end
    offer(32'h200);
    check("full_ready", 32'(fetchReady), 32'd0);
    check("full_count", 32'(count),      32'd4);
    tick();
    check("full_hold",  32'(count),      32'd4);
    fetchValid = 1'b0; decodeReady = 1'b1;
    tick();
    decodeReady = 1'b0;
    check("reopen_ready", 32'(fetchReady), 32'd1);
    decodeReady = 1'b1;
    tick(); tick(); tick();
    decodeReady = 1'b0;
    check("full_drained", 32'(count), 32'd0);

    // Streaming: one in, one out every cycle; count holds at one.
    offer(32'h0); tick();
    decodeReady = 1'b1;
    for (int i = 1; i < 20; i++) begin
      offer(32'(4 * i)); tick();
      check("stream_count", 32'(count), 32'd1);
    end
    fetchValid = 1'b0;
    tick();
    decodeReady = 1'b0;
    check("stream_end", 32'(count), 32'd0);

    // Flush with simultaneous offer and dequeue.
    for (int i = 0; i < 3; i++) begin offer(32'h300 + 32'(4 * i)); tick(); end
    offer(32'hDEAD0000); decodeReady = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; fetchValid = 1'b0; decodeReady = 1'b0;
    check("flush_count", 32'(count),       32'd0);
    check("flush_valid", 32'(decodeValid), 32'd0);
    tick();
    check("flush_absent", 32'(count), 32'd0);

    // Reset beats flush mid-operation.
    for (int i = 0; i < 2; i++) begin offer(32'h400 + 32'(4 * i)); tick(); end
    fetchValid = 1'b0;
    check("pre_rst_count", 32'(count), 32'd2);
    reset = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0;
    check("mid_rst_count", 32'(count),       32'd0);
    check("mid_rst_valid", 32'(decodeValid), 32'd0);
    check("mid_rst_ready", 32'(fetchReady),  32'd1);
    check("mid_rst_ins",   decodeInstruction, 32'h00000013);
    check("mid_rst_pc",    decodePC,          32'h0);

    // Pointers must restart at zero after reset.
    offer(32'h500); tick();
    fetchValid = 1'b0;
    check("post_rst_pc", decodePC, 32'h500);
    decodeReady = 1'b1; tick(); decodeReady = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jzjpcc_instruction_queue.md
JZJPCC_INSTRUCTION_QUEUE -- requirements
Module: jzjpcc_instruction_queue

Interface
REQ-001 The block SHALL take parameter DEPTH, default 4, giving queue entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port fetchValid  input  1  fetch stage presents an instruction.
REQ-005 The block SHALL have port fetchReady  output  1  queue can accept an entry this cycle.
REQ-006 The block SHALL have port fetchPC  input  32  address of the presented instruction.
REQ-007 The block SHALL have port fetchInstruction  input  32  presented instruction word.
REQ-008 The block SHALL have port decodeValid  output  1  head entry is available to decode.
REQ-009 The block SHALL have port decodeReady  input  1  decode consumes the head entry this cycle.
REQ-010 The block SHALL have port decodePC  output  32  PC of the head entry.
REQ-011 The block SHALL have port decodeInstruction  output  32  instruction word of the head entry.
REQ-012 The block SHALL have port flush  input  1  discard all entries (branch/jump redirect).
REQ-013 The block SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-014 Enqueue SHALL occur on a rising edge where fetchValid && fetchReady && !flush.
REQ-015 Dequeue SHALL occur on a rising edge where decodeValid && decodeReady && !flush.
REQ-016 fetchReady SHALL equal (count != DEPTH) and SHALL NOT depend combinationally on decodeReady or fetchValid.
REQ-017 decodeValid SHALL equal (count != 0); decodePC/decodeInstruction SHALL come from registered head storage, with no combinational path from fetch inputs.
REQ-018 Latency SHALL be one cycle: an entry enqueued at edge N is visible on decode outputs from cycle N+1 if the queue was empty.
REQ-019 When decodeValid is 0, decodeInstruction SHALL read 32'h00000013 (NOP) and decodePC SHALL read 32'h00000000.
REQ-020 Entries SHALL leave in strict FIFO order; read/write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-021 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-022 When full, a dequeue in that cycle SHALL NOT permit enqueue in the same cycle (fetchReady is already 0).
REQ-023 When empty, decodeReady SHALL have no effect.
REQ-024 flush SHALL, at the next edge, set count to 0 and both pointers to 0, overriding any simultaneous enqueue or dequeue; the fetch-side word offered during flush is dropped.
REQ-025 fetchValid SHALL be allowed to drop without an accept; the queue holds no obligation to a non-accepted word.
REQ-026 Holding decodeReady low SHALL keep decode outputs stable while decodeValid is 1.

Reset
REQ-027 On reset, count, both pointers SHALL go to 0, decodeValid to 0, fetchReady to 1, decodeInstruction to NOP, decodePC to 0.
REQ-028 reset SHALL take priority over flush, enqueue and dequeue; asserted mid-operation it discards all contents at that edge.
REQ-029 Storage array contents need not be reset.

Structure
REQ-030 The NOP constant (32'h00000013) and a 32-bit word typedef SHALL live in shared package jzjpcc_pkg.
REQ-031 No sub-module SHALL be used; storage is a register array inside jzjpcc_instruction_queue.

Verification
REQ-032 Reset then idle: decodeValid=0, fetchReady=1, count=0, decodeInstruction=32'h00000013.
REQ-033 Enqueue PC 0x0/0x4/0x8 with decodeReady=0 -> count=3; then decodeReady=1 -> outputs appear in order 0x0, 0x4, 0x8, one per cycle.
REQ-034 Enqueue 4 words (DEPTH=4) -> fifth offer sees fetchReady=0, count=4; single dequeue -> fetchReady=1 next cycle.
REQ-035 Steady streaming enqueue+dequeue every cycle for 20 cycles -> count constant at 1, pointers wrap, PCs 0x0..0x4C in order.
REQ-036 Queue holding 3 entries, flush with simultaneous fetchValid and decodeReady -> next cycle count=0, decodeValid=0, offered word absent.
REQ-037 Reset asserted with count=2 and flush=1 -> next cycle all reset values of REQ-027.
